// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: shifts DATA_WIDTH bits MSB-first using an external SPI clock generator; rx_valid one cycle after DONE.
// Backpressure: tx_ready is high only in IDLE, so requests arriving mid-transfer are ignored.
module spi_master_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  clkgen_en,
  input  logic                  spi_clk_in,
  output logic                  spi_cs_n,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] tx_shift, tx_shift_nxt;
  logic [DATA_WIDTH-1:0] rx_shift, rx_shift_nxt;
  logic [DATA_WIDTH-1:0] rx_data_nxt;
  logic [CW-1:0]         bit_cnt, bit_cnt_nxt;
  logic                  spi_clk_d, clk_rise, clk_fall;
  logic                  tx_ready_nxt, rx_valid_nxt, busy_nxt;
  logic                  clkgen_en_nxt, spi_cs_n_nxt, spi_mosi_nxt;

  assign clk_rise = spi_clk_in & ~spi_clk_d;
  assign clk_fall = ~spi_clk_in & spi_clk_d;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      bit_cnt   <= '0;
      spi_clk_d <= 1'b0;
      tx_ready  <= 1'b1;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      clkgen_en <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_mosi  <= 1'b0;
    end else begin
      state     <= state_nxt;
      tx_shift  <= tx_shift_nxt;
      rx_shift  <= rx_shift_nxt;
      rx_data   <= rx_data_nxt;
      bit_cnt   <= bit_cnt_nxt;
      spi_clk_d <= spi_clk_in;
      tx_ready  <= tx_ready_nxt;
      rx_valid  <= rx_valid_nxt;
      busy      <= busy_nxt;
      clkgen_en <= clkgen_en_nxt;
      spi_cs_n  <= spi_cs_n_nxt;
      spi_mosi  <= spi_mosi_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    tx_shift_nxt  = tx_shift;
    rx_shift_nxt  = rx_shift;
    rx_data_nxt   = rx_data;
    bit_cnt_nxt   = bit_cnt;
    tx_ready_nxt  = tx_ready;
    rx_valid_nxt  = 1'b0;
    busy_nxt      = busy;
    clkgen_en_nxt = clkgen_en;
    spi_cs_n_nxt  = spi_cs_n;
    spi_mosi_nxt  = spi_mosi;

    case (state)
      IDLE: begin
        if (tx_valid) begin
          tx_shift_nxt = tx_data;
          spi_mosi_nxt = tx_data[DATA_WIDTH-1];
          spi_cs_n_nxt = 1'b0;
          bit_cnt_nxt  = '0;
          tx_ready_nxt = 1'b0;
          busy_nxt     = 1'b1;
          state_nxt    = SETUP;
        end
      end
      SETUP: begin
        clkgen_en_nxt = 1'b1;
        state_nxt     = XFER;
      end
      XFER: begin
        if (clk_rise) begin
          rx_shift_nxt = {rx_shift[DATA_WIDTH-2:0], spi_miso};
          bit_cnt_nxt  = bit_cnt + CW'(1);
        end else if (clk_fall) begin
          // The falling edge after the last sample ends the transfer; mosi holds its last bit.
          if (bit_cnt == LAST_BIT) begin
            clkgen_en_nxt = 1'b0;
            state_nxt     = DONE;
          end else begin
            tx_shift_nxt = {tx_shift[DATA_WIDTH-2:0], 1'b0};
            spi_mosi_nxt = tx_shift[DATA_WIDTH-2];
          end
        end
      end
      DONE: begin
        rx_data_nxt  = rx_shift;
        rx_valid_nxt = 1'b1;
        spi_cs_n_nxt = 1'b1;
        tx_ready_nxt = 1'b1;
        busy_nxt     = 1'b0;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl with a divide-by-4 SPI clock generator and mosi looped back to miso.
module tb_spi_master_ctrl;
  localparam int W   = 8;
  localparam int DIV = 4;

  logic         sys_clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tx_valid = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_ready, rx_valid, busy, clkgen_en, spi_cs_n, spi_mosi, spi_miso;
  logic [W-1:0] rx_data;
  logic         spi_clk_in = 1'b0;
  logic [1:0]   gcnt = '0;
  logic         force_miso = 1'b0;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_q[$];
  int           rises = 0;
  int           last_gap = 0;
  bit           mosi_hi = 1'b0;

  always #5 sys_clk = ~sys_clk;

  assign spi_miso = force_miso ? 1'b1 : spi_mosi;

  spi_master_ctrl #(.DATA_WIDTH(W)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .clkgen_en(clkgen_en), .spi_clk_in(spi_clk_in), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  // SPI clock generator: toggles every DIV cycles while enabled, parked low otherwise.
  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt <= '0;
      spi_clk_in <= 1'b0;
    end else if (!clkgen_en) begin
      gcnt <= '0;
      spi_clk_in <= 1'b0;
    end else if (gcnt == 2'(DIV - 1)) begin
      gcnt <= '0;
      spi_clk_in <= ~spi_clk_in;
    end else begin
      gcnt <= gcnt + 2'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic chk_min(input string name, input int act, input int req_min);
    n_checks++;
    if (act < req_min) begin
      n_fail++;
      $display("FAIL %s: actual %0d required >= %0d", name, act, req_min);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual timeout required completion", name);
  endtask

  // Monitor: scoreboard pops on rx_valid, plus SPI timing and framing checks.
  initial begin
    int edge_gap, cs_cyc, hi_cnt, stable;
    bit have_edge, prev_clk, prev_cs, prev_mosi, clk_hi_idle;
    bit rise, fall, cs_fall;
    logic [W-1:0] exp_word;
    edge_gap = 0; cs_cyc = 0; hi_cnt = 0; stable = 0;
    have_edge = 0; prev_clk = 0; prev_cs = 1; prev_mosi = 0; clk_hi_idle = 0;
    forever begin
      @(negedge sys_clk);
      if (!rst_n) begin
        rises = 0; hi_cnt = 0; have_edge = 0; clk_hi_idle = 0; stable = 0;
        prev_clk = 0; prev_cs = 1; prev_mosi = 0;
      end else begin
        rise    = spi_clk_in && !prev_clk;
        fall    = !spi_clk_in && prev_clk;
        cs_fall = !spi_cs_n && prev_cs;
        edge_gap++;
        cs_cyc++;
        if (cs_fall) begin
          chk("clk_low_between", {31'd0, clk_hi_idle}, 0);
          chk("setup_en_low", {31'd0, clkgen_en}, 0);
          chk("busy_on_accept", {31'd0, busy}, 1);
          chk("ready_on_accept", {31'd0, tx_ready}, 0);
          last_gap = hi_cnt;
          hi_cnt = 0; rises = 0; have_edge = 0; cs_cyc = 0; mosi_hi = 0; clk_hi_idle = 0;
        end
        if (spi_cs_n) begin
          hi_cnt++;
          if (spi_clk_in) clk_hi_idle = 1;
        end
        if (!spi_cs_n && spi_mosi) mosi_hi = 1;
        if (!spi_cs_n && cs_cyc == 1) chk("xfer_en_high", {31'd0, clkgen_en}, 1);
        if (rise && !spi_cs_n) begin
          rises++;
          if (rises == 1) chk("first_rise_delay", cs_cyc, 5);
          chk_min("mosi_setup", (spi_mosi == prev_mosi) ? stable : 0, 3);
        end
        if ((rise || fall) && !spi_cs_n) begin
          if (have_edge) chk("edge_spacing", edge_gap, DIV);
          have_edge = 1;
          edge_gap = 0;
        end
        if (spi_mosi != prev_mosi) stable = 1;
        else stable++;
        if (rx_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_unexpected: actual pulse with 0x%0h required no pulse", rx_data);
          end else begin
            exp_word = exp_q.pop_front();
            chk("rx_data", rx_data, exp_word);
            chk("rise_count", rises, W);
          end
        end
        prev_clk = spi_clk_in; prev_cs = spi_cs_n; prev_mosi = spi_mosi;
      end
    end
  end

  task automatic wait_ready(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (tx_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      #1;
      if (exp_q.size() == 0 && tx_ready && spi_cs_n) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_rises(input string name, input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      #1;
      if (rises >= n) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout(name);
  endtask

  task automatic send(input logic [W-1:0] word, input logic [W-1:0] expect_rx);
    wait_ready("send_ready");
    tx_valid = 1'b1;
    tx_data  = word;
    exp_q.push_back(expect_rx);
    @(posedge sys_clk);
    #1 tx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("rst_cs_n", {31'd0, spi_cs_n}, 1);
    chk("rst_clkgen_en", {31'd0, clkgen_en}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_mosi", {31'd0, spi_mosi}, 0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 1);
    rst_n = 1'b1;

    // Loopback of a mixed pattern, then rx_data must hold while idle.
    send(8'hA5, 8'hA5);
    wait_done("a5_done");
    repeat (10) @(negedge sys_clk);
    chk("rx_hold", rx_data, 8'hA5);

    // All-zero word with miso tied high.
    force_miso = 1'b1;
    send(8'h00, 8'hFF);
    wait_done("zero_done");
    chk("mosi_held_low", {31'd0, mosi_hi}, 0);
    force_miso = 1'b0;

    // Back-to-back with tx_valid held high.
    wait_ready("b2b_ready1");
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    @(posedge sys_clk);
    #1 tx_data = 8'hC3;
    wait_ready("b2b_ready2");
    @(posedge sys_clk);
    #1 tx_valid = 1'b0;
    wait_done("b2b_done");
    chk("b2b_cs_gap", last_gap, 1);

    // A different word offered mid-transfer is ignored.
    send(8'h96, 8'h96);
    wait_rises("ignore_rises", 2);
    tx_valid = 1'b1;
    tx_data  = 8'h69;
    @(posedge sys_clk);
    #1 chk("ready_in_xfer", {31'd0, tx_ready}, 0);
    tx_valid = 1'b0;
    wait_done("ignore_done");
    repeat (5) @(negedge sys_clk);
    chk("no_extra_xfer", {31'd0, spi_cs_n}, 1);

    // Reset after the third rising edge aborts silently.
    wait_ready("abort_ready");
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    @(posedge sys_clk);
    #1 tx_valid = 1'b0;
    wait_rises("abort_rises", 3);
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", {31'd0, spi_cs_n}, 1);
    chk("abort_clkgen_en", {31'd0, clkgen_en}, 0);
    chk("abort_rx_data", rx_data, 0);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1 chk("release_tx_ready", {31'd0, tx_ready}, 1);
    send(8'h5A, 8'h5A);
    wait_done("post_reset_done");

    repeat (20) @(negedge sys_clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets bits per transfer; legal range 2..32.
REQ-002 sys_clk  in  1  system clock; all logic on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 tx_valid  in  1  request to start one transfer.
REQ-005 tx_data  in  DATA_WIDTH  word to send, MSB first.
REQ-006 tx_ready  out  1  high when a new request is accepted.
REQ-007 rx_valid  out  1  one-cycle pulse, rx_data valid.
REQ-008 rx_data  out  DATA_WIDTH  word received, first bit in MSB.
REQ-009 busy  out  1  high from accept until return to IDLE.
REQ-010 clkgen_en  out  1  enable to the SPI clock generator.
REQ-011 spi_clk_in  in  1  SPI clock from the clock generator, synchronous to sys_clk, low while idle.
REQ-012 spi_cs_n  out  1  chip select, active-low.
REQ-013 spi_mosi  out  1  serial data out.
REQ-014 spi_miso  in  1  serial data in.

Function
REQ-015 The block SHALL implement SPI mode 0: spi_mosi changes only after spi_clk_in falling edges or in SETUP; spi_miso is sampled on spi_clk_in rising edges.
REQ-016 Edge detection SHALL use a register spi_clk_d: rise = spi_clk_in & ~spi_clk_d, fall = ~spi_clk_in & spi_clk_d, each one sys_clk cycle wide.
REQ-017 FSM states: IDLE, SETUP, XFER, DONE; all outputs registered.
REQ-018 IDLE: tx_ready=1, busy=0, spi_cs_n=1, clkgen_en=0; on tx_valid=1, latch tx_data, spi_mosi<=tx_data[MSB], spi_cs_n<=0, bit_cnt<=0, go to SETUP.
REQ-019 SETUP: lasts exactly one cycle; clkgen_en<=1, go to XFER.
REQ-020 XFER on rise: rx_shift <= {rx_shift[W-2:0], spi_miso}; bit_cnt <= bit_cnt+1.
REQ-021 XFER on fall with bit_cnt < DATA_WIDTH: tx_shift shifts left one bit; spi_mosi <= new MSB.
REQ-022 XFER on fall with bit_cnt == DATA_WIDTH: clkgen_en<=0, spi_mosi unchanged, go to DONE.
REQ-023 DONE: lasts one cycle; rx_data<=rx_shift, rx_valid<=1 for that one cycle, spi_cs_n<=1, go to IDLE.
REQ-024 tx_ready SHALL be low in SETUP, XFER, and DONE; tx_valid SHALL be ignored in those states.
REQ-025 A request presented in the cycle DONE returns to IDLE SHALL be accepted in the following cycle; spi_cs_n is high for at least one cycle between transfers.
REQ-026 bit_cnt width SHALL be clog2(DATA_WIDTH+1); no wrap within a transfer.
REQ-027 Exactly DATA_WIDTH rising and DATA_WIDTH falling spi_clk_in edges SHALL occur per transfer; spi_clk_in ends low.
REQ-028 Precondition: the clock generator half-period is at least 2 sys_clk cycles, so clkgen_en drops before any further toggle.
REQ-029 Simultaneous rise and fall cannot occur; the block does not need to handle that case.
REQ-030 rx_data SHALL hold its value until the next DONE.

Reset
REQ-031 When rst_n=0, asynchronously: state=IDLE, spi_cs_n=1, clkgen_en=0, spi_mosi=0, rx_valid=0, rx_data=0, busy=0, shift registers and bit_cnt=0, spi_clk_d=0.
REQ-032 Reset during XFER SHALL abort the transfer with no rx_valid pulse; after release, the block is in IDLE and tx_ready=1 in the first cycle.

Verification
REQ-033 Bench pairs the block with the clock generator, divider 4, and mosi looped to miso. Send tx_data=0xA5 -> rx_valid pulses once, rx_data=0xA5, 8 rising edges seen while spi_cs_n=0.
REQ-034 tx_data=0x00 with spi_miso held at 1 -> rx_data=0xFF; spi_mosi stays 0 for the whole transfer.
REQ-035 Back-to-back: tx_valid held high with 0x3C and then 0xC3 -> two rx_valid pulses with rx_data 0x3C then 0xC3; spi_cs_n high for at least 1 cycle between them; spi_clk_in low between them.
REQ-036 tx_valid pulsed during XFER with a different word -> the word is ignored; the current transfer completes unchanged.
REQ-037 rst_n pulsed low after the 3rd rising edge -> immediate spi_cs_n=1 and clkgen_en=0; no rx_valid; a following transfer of 0x5A returns 0x5A.
REQ-038 Timing check, divider 4, DATA_WIDTH 8: spi_cs_n falls, 1 SETUP cycle follows, then the first rising edge appears at the generator period. Edge-to-edge spacing is 4 cycles, and spi_mosi is stable for at least 3 cycles before each rising edge.
